// File: rtl/ryuki_datatypes.sv
// Shared trace types: the per-instruction trace record and the stage FSM encodings.
package ryuki_datatypes;

    localparam int TS_WIDTH = 32;

    // One completed instruction as seen by the IF, ID and EX stages.
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] addr;
        logic [31:0] if_start;
        logic [31:0] if_end;
        logic [31:0] id_start;
        logic [31:0] id_end;
        logic [31:0] ex_start;
        logic [31:0] ex_end;
        logic [31:0] mem_addr;
        logic [31:0] mem_start;
        logic [31:0] mem_end;
    } trace_output;

    typedef enum logic {
        IF_IDLE,
        IF_WAIT_RVALID
    } if_state_t;

    typedef enum logic {
        ID_IDLE,
        ID_DECODE
    } id_state_t;

    typedef enum logic {
        EX_IDLE,
        EX_EXEC
    } ex_state_t;

endpackage

// File: rtl/trace_record_fifo.sv
// Small first-word-fall-through queue of trace records. A push into a full
// queue is ignored (the parent flags it); a pop of an empty queue is ignored.
module trace_record_fifo
    import ryuki_datatypes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  trace_output push_data,
    input  logic        pop,
    output trace_output pop_data,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty can be told apart.
    logic [PTR_W:0] wr_ptr_reg;
    logic [PTR_W:0] rd_ptr_reg;
    trace_output    mem_reg [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head record is visible combinationally so a consumer can pop and use it in one cycle.
    assign pop_data = mem_reg[rd_ptr_reg[PTR_W-1:0]];

    // Storage write; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        end
    end

    // Pointer update; both may move in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_stage_tracker.sv
// Passive IF/ID/EX observer: assembles one trace record per instruction,
// stamping each stage with the parent's cycle counter, and emits it when EX retires.
module pipeline_stage_tracker
    import ryuki_datatypes::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           counter,
    input  logic                  if_busy,
    input  logic                  if_ready,
    input  logic                  instr_req,
    input  logic                  instr_grant,
    input  logic                  instr_rvalid,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    input  logic                  is_decoding,
    input  logic                  jump_done,
    input  logic                  ex_ready,
    input  logic                  data_req_i,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    output logic                  ex_data_ready,
    output trace_output           ex_data_o,
    output logic                  trace_overflow
);

    // IF stage status is not needed to delimit records; the memory handshake does that.
    logic unused_if_status;
    assign unused_if_status = if_busy ^ if_ready;

    // ---------------- IF stage ----------------
    if_state_t   if_state_reg;
    logic [31:0] if_addr_reg;
    logic [31:0] if_start_reg;
    logic        if_push;
    trace_output if_push_data;

    logic        if_full;
    logic        if_empty;
    logic        id_pop;
    trace_output if_pop_data;

    assign if_push = (if_state_reg == IF_WAIT_RVALID) && instr_rvalid;

    // Record handed to the IF queue when the instruction data returns.
    always_comb begin
        if_push_data             = '0;
        if_push_data.instruction = 32'(instr_rdata);
        if_push_data.addr        = if_addr_reg;
        if_push_data.if_start    = if_start_reg;
        if_push_data.if_end      = counter;
    end

    // IF FSM: open a record on req&grant, close it on rvalid; both in one cycle chain back-to-back fetches.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_state_reg <= IF_IDLE;
            if_addr_reg  <= '0;
            if_start_reg <= '0;
        end else begin
            case (if_state_reg)
                IF_IDLE: begin
                    if (instr_req && instr_grant) begin
                        if_addr_reg  <= 32'(instr_addr);
                        if_start_reg <= counter;
                        if_state_reg <= IF_WAIT_RVALID;
                    end
                end
                IF_WAIT_RVALID: begin
                    if (instr_rvalid) begin
                        if (instr_req && instr_grant) begin
                            if_addr_reg  <= 32'(instr_addr);
                            if_start_reg <= counter;
                        end else begin
                            if_state_reg <= IF_IDLE;
                        end
                    end
                end
                default: if_state_reg <= IF_IDLE;
            endcase
        end
    end

    trace_record_fifo #(.DEPTH(QUEUE_DEPTH)) if_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (if_push),
        .push_data (if_push_data),
        .pop       (id_pop),
        .pop_data  (if_pop_data),
        .full      (if_full),
        .empty     (if_empty)
    );

    // ---------------- ID stage ----------------
    id_state_t   id_state_reg;
    trace_output id_rec_reg;
    logic        ex_push;
    trace_output ex_push_data;

    assign id_pop  = (id_state_reg == ID_IDLE) && is_decoding && !if_empty;
    assign ex_push = (id_state_reg == ID_DECODE) && (!is_decoding || jump_done);

    // Record handed to the EX queue when decode finishes.
    always_comb begin
        ex_push_data        = id_rec_reg;
        ex_push_data.id_end = counter;
    end

    // ID FSM: take the oldest fetched record when decode starts, release it when decode ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_state_reg <= ID_IDLE;
            id_rec_reg   <= '0;
        end else begin
            case (id_state_reg)
                ID_IDLE: begin
                    if (id_pop) begin
                        id_rec_reg          <= if_pop_data;
                        id_rec_reg.id_start <= counter;
                        id_state_reg        <= ID_DECODE;
                    end
                end
                ID_DECODE: begin
                    if (ex_push) begin
                        id_state_reg <= ID_IDLE;
                    end
                end
                default: id_state_reg <= ID_IDLE;
            endcase
        end
    end

    // ---------------- EX stage ----------------
    logic        ex_full;
    logic        ex_empty;
    logic        ex_pop;
    trace_output ex_pop_data;

    trace_record_fifo #(.DEPTH(QUEUE_DEPTH)) ex_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (ex_push),
        .push_data (ex_push_data),
        .pop       (ex_pop),
        .pop_data  (ex_pop_data),
        .full      (ex_full),
        .empty     (ex_empty)
    );

    ex_state_t   ex_state_reg;
    trace_output ex_rec_reg;
    logic        pending_reg;
    logic        ex_data_ready_reg;
    trace_output ex_data_reg;

    logic        ex_active;
    logic        mem_grant;
    logic        pending_next;
    logic        ex_done;
    trace_output ex_rec_next;

    // The pop cycle already counts as executing, so a single-cycle EX retires in the cycle it starts.
    assign ex_pop    = (ex_state_reg == EX_IDLE) && !ex_empty;
    assign ex_active = ex_pop || (ex_state_reg == EX_EXEC);
    assign mem_grant = data_req_i && data_gnt_i;

    // A new grant keeps the access pending even if an older response lands in the same cycle.
    always_comb begin
        pending_next = pending_reg;
        if (mem_grant) begin
            pending_next = 1'b1;
        end else if (data_rvalid_i) begin
            pending_next = 1'b0;
        end
    end

    assign ex_done = ex_active && ex_ready && !pending_next;

    // Working record for this cycle with any memory handshake folded in.
    always_comb begin
        ex_rec_next = ex_rec_reg;
        if (ex_pop) begin
            ex_rec_next          = ex_pop_data;
            ex_rec_next.ex_start = counter;
        end
        if (pending_reg && data_rvalid_i) begin
            ex_rec_next.mem_end = counter;
        end
        if (mem_grant) begin
            ex_rec_next.mem_addr  = 32'(data_addr_i);
            ex_rec_next.mem_start = counter;
        end
    end

    // EX FSM: track the access window, retire on ex_ready with nothing outstanding, emit a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_state_reg      <= EX_IDLE;
            ex_rec_reg        <= '0;
            pending_reg       <= 1'b0;
            ex_data_ready_reg <= 1'b0;
            ex_data_reg       <= '0;
        end else begin
            ex_data_ready_reg <= 1'b0;
            if (ex_active) begin
                if (ex_done) begin
                    ex_data_reg        <= ex_rec_next;
                    ex_data_reg.ex_end <= counter;
                    ex_data_ready_reg  <= 1'b1;
                    ex_state_reg       <= EX_IDLE;
                    pending_reg        <= 1'b0;
                end else begin
                    ex_rec_reg   <= ex_rec_next;
                    pending_reg  <= pending_next;
                    ex_state_reg <= EX_EXEC;
                end
            end
        end
    end

    // Sticky flag for any record lost to a full queue.
    logic trace_overflow_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_overflow_reg <= 1'b0;
        end else if ((if_push && if_full) || (ex_push && ex_full)) begin
            trace_overflow_reg <= 1'b1;
        end
    end

    assign ex_data_ready  = ex_data_ready_reg;
    assign ex_data_o      = ex_data_reg;
    assign trace_overflow = trace_overflow_reg;

endmodule

// File: tb/tb_pipeline_stage_tracker.sv
// Bench for pipeline_stage_tracker: table of single-instruction vectors plus
// hand-written back-to-back, overflow and mid-execution reset sequences.
module tb_pipeline_stage_tracker;
    import ryuki_datatypes::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] counter;
    logic        if_busy, if_ready;
    logic        instr_req, instr_grant, instr_rvalid;
    logic [31:0] instr_addr, instr_rdata;
    logic        is_decoding, jump_done, ex_ready;
    logic        data_req_i, data_gnt_i, data_rvalid_i;
    logic [31:0] data_addr_i;
    logic        ex_data_ready;
    trace_output ex_data_o;
    logic        trace_overflow;

    always #5 clk = ~clk;

    pipeline_stage_tracker dut (
        .clk            (clk),
        .rst            (rst),
        .counter        (counter),
        .if_busy        (if_busy),
        .if_ready       (if_ready),
        .instr_req      (instr_req),
        .instr_grant    (instr_grant),
        .instr_rvalid   (instr_rvalid),
        .instr_addr     (instr_addr),
        .instr_rdata    (instr_rdata),
        .is_decoding    (is_decoding),
        .jump_done      (jump_done),
        .ex_ready       (ex_ready),
        .data_req_i     (data_req_i),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_addr_i    (data_addr_i),
        .ex_data_ready  (ex_data_ready),
        .ex_data_o      (ex_data_o),
        .trace_overflow (trace_overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        trace_output rec;
        int          t;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          gnt_t, rv_t, dec_s, dec_e, jd_t, exr_t, mg_t, mrv_t;
        logic [31:0] maddr;
        trace_output exp;
        int          pulse_t;
    } vec_t;

    function automatic trace_output mk(input logic [31:0] ins, input logic [31:0] a,
                                       input int ifs, input int ife, input int ids, input int ide,
                                       input int exs, input int exe, input logic [31:0] ma,
                                       input int ms, input int me);
        trace_output r;
        r.instruction = ins;       r.addr     = a;
        r.if_start    = 32'(ifs);  r.if_end   = 32'(ife);
        r.id_start    = 32'(ids);  r.id_end   = 32'(ide);
        r.ex_start    = 32'(exs);  r.ex_end   = 32'(exe);
        r.mem_addr    = ma;
        r.mem_start   = 32'(ms);   r.mem_end  = 32'(me);
        return r;
    endfunction

    function automatic void expect_rec(input trace_output r, input int t);
        sb_t e;
        e.rec = r;
        e.t   = t;
        sbq.push_back(e);
    endfunction

    // Scoreboard: every strobe must match the oldest expected record and arrive in the expected cycle.
    always @(negedge clk) begin
        if (!rst && ex_data_ready) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_record t=%0d got=%h", counter, ex_data_o);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                if (ex_data_o !== e.rec || counter != 32'(e.t)) begin
                    n_bad++;
                    $display("FAIL record t=%0d want_t=%0d got=%h want=%h", counter, e.t, ex_data_o, e.rec);
                end else begin
                    $display("record ok t=%0d addr=%h instr=%h", counter, ex_data_o.addr, ex_data_o.instruction);
                end
            end
        end
    end

    task automatic idle_inputs();
        if_busy = 0; if_ready = 1;
        instr_req = 0; instr_grant = 0; instr_rvalid = 0;
        instr_addr = '0; instr_rdata = '0;
        is_decoding = 0; jump_done = 0; ex_ready = 0;
        data_req_i = 0; data_gnt_i = 0; data_rvalid_i = 0; data_addr_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0b want=%0b", name, got, want);
        end else begin
            $display("check ok %s=%0b", name, got);
        end
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        rst = 1;
        counter = '0;
        for (int i = 0; i < cycles; i++) tick();
        rst = 0;
    endtask

    task automatic run_vec(input vec_t v);
        expect_rec(v.exp, v.pulse_t);
        for (int t = 0; t < 24; t++) begin
            counter       = 32'(t);
            instr_req     = (t == v.gnt_t);
            instr_grant   = (t == v.gnt_t);
            instr_addr    = v.addr;
            instr_rvalid  = (t == v.rv_t);
            instr_rdata   = v.rdata;
            is_decoding   = (t >= v.dec_s) && (t < v.dec_e);
            jump_done     = (t == v.jd_t);
            ex_ready      = (t >= v.exr_t);
            data_req_i    = (t == v.mg_t);
            data_gnt_i    = (t == v.mg_t);
            data_rvalid_i = (t == v.mrv_t);
            data_addr_i   = v.maddr;
            tick();
        end
        idle_inputs();
    endtask

    vec_t vecs[5];

    initial begin
        // addr, rdata, gnt, rv, dec_s, dec_e, jd, exr, mg, mrv, maddr, expected record, pulse cycle
        vecs[0] = '{32'h80, 32'h00100093, 5, 7, 8, 9, -1, 10, -1, -1, 32'h0,
                    mk(32'h00100093, 32'h80, 5, 7, 8, 9, 10, 10, 32'h0, 0, 0), 11};
        vecs[1] = '{32'h84, 32'h00002083, 5, 7, 8, 9, -1, 11, 11, 13, 32'h1000,
                    mk(32'h00002083, 32'h84, 5, 7, 8, 9, 10, 13, 32'h1000, 11, 13), 14};
        vecs[2] = '{32'hFFFFFFFC, 32'hDEADBEEF, 2, 6, 7, 12, -1, 15, -1, -1, 32'h0,
                    mk(32'hDEADBEEF, 32'hFFFFFFFC, 2, 6, 7, 12, 13, 15, 32'h0, 0, 0), 16};
        vecs[3] = '{32'h40, 32'h0000A103, 1, 2, 3, 5, -1, 8, 7, 9, 32'h3000,
                    mk(32'h0000A103, 32'h40, 1, 2, 3, 5, 6, 9, 32'h3000, 7, 9), 10};
        vecs[4] = '{32'h90, 32'h0080006F, 3, 4, 5, 20, 7, 8, -1, -1, 32'h0,
                    mk(32'h0080006F, 32'h90, 3, 4, 5, 7, 8, 8, 32'h0, 0, 0), 9};

        // Reset state
        do_reset(2);
        check1("reset_ex_data_ready", ex_data_ready, 1'b0);
        check1("reset_overflow", trace_overflow, 1'b0);
        n_cmp++;
        if (ex_data_o !== '0) begin
            n_bad++;
            $display("FAIL reset_ex_data_o got=%h want=0", ex_data_o);
        end

        // Single-instruction vectors
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Back-to-back fetches 0x80, 0x84, 0x88
        do_reset(1);
        expect_rec(mk(32'h00100093, 32'h80, 2, 3, 6, 7, 8, 8, 32'h0, 0, 0), 9);
        expect_rec(mk(32'h00208113, 32'h84, 3, 4, 8, 9, 10, 10, 32'h0, 0, 0), 11);
        expect_rec(mk(32'h00310193, 32'h88, 4, 5, 10, 11, 12, 12, 32'h0, 0, 0), 13);
        for (int t = 0; t < 18; t++) begin
            counter      = 32'(t);
            instr_req    = (t >= 2 && t <= 4);
            instr_grant  = (t >= 2 && t <= 4);
            instr_addr   = 32'h80 + 32'((t - 2) * 4);
            instr_rvalid = (t >= 3 && t <= 5);
            instr_rdata  = (t == 3) ? 32'h00100093 : (t == 4) ? 32'h00208113 : 32'h00310193;
            is_decoding  = (t == 6 || t == 8 || t == 10);
            ex_ready     = 1'b1;
            tick();
        end
        idle_inputs();

        // ID stalled: five fetches into a four-deep queue, fifth is dropped
        do_reset(1);
        for (int k = 0; k < 4; k++)
            expect_rec(mk(32'hA0 + 32'(k), 32'h100 + 32'(4 * k), k + 1, k + 2,
                          8 + 2 * k, 9 + 2 * k, 10 + 2 * k, 10 + 2 * k, 32'h0, 0, 0), 11 + 2 * k);
        for (int t = 0; t < 22; t++) begin
            counter = 32'(t);
            if (t == 6) check1("overflow_before_drop", trace_overflow, 1'b0);
            if (t == 7) check1("overflow_after_drop", trace_overflow, 1'b1);
            instr_req    = (t >= 1 && t <= 5);
            instr_grant  = (t >= 1 && t <= 5);
            instr_addr   = 32'h100 + 32'((t - 1) * 4);
            instr_rvalid = (t >= 2 && t <= 6);
            instr_rdata  = 32'hA0 + 32'(t - 2);
            is_decoding  = (t >= 8 && t <= 14 && (t % 2 == 0));
            ex_ready     = 1'b1;
            tick();
        end
        idle_inputs();
        check1("overflow_sticky", trace_overflow, 1'b1);
        do_reset(1);
        check1("overflow_cleared_by_rst", trace_overflow, 1'b0);

        // Reset while an instruction is in EXEC: its record must vanish
        for (int t = 0; t < 16; t++) begin
            counter      = 32'(t);
            rst          = (t == 7);
            instr_req    = (t == 1 || t == 3);
            instr_grant  = (t == 1 || t == 3);
            instr_addr   = (t == 1) ? 32'h200 : 32'h204;
            instr_rvalid = (t == 2 || t == 4);
            instr_rdata  = 32'h00000013;
            is_decoding  = (t == 3) || (t >= 8);
            ex_ready     = (t >= 8);
            tick();
        end
        rst = 0;
        idle_inputs();
        check1("no_strobe_after_mid_reset", ex_data_ready, 1'b0);
        n_cmp++;
        if (ex_data_o !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_ex_data_o got=%h want=0", ex_data_o);
        end
        run_vec(vecs[0]);

        // Everything expected must have been delivered
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL missing_records got=%0d want=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
